// File: rtl/bus_arbiter_if.sv
// Shared-bus signal bundle between the four requesters and the arbiter.
// master = arbiter side (drives grant/bus), slave = requester side.
interface bus_arbiter_if #(
  parameter int DATA_W = 8
);
  // req is level-sensitive and never latched. gnt/owner/bus_valid are registered.
  // bus carries drv_data of owner in the same cycle while bus_valid=1 and is zero otherwise.
  logic [3:0]          req;
  logic [4*DATA_W-1:0] drv_data;
  logic [3:0]          gnt;
  logic [1:0]          owner;
  logic                bus_valid;
  logic [DATA_W-1:0]   bus;

  modport master (
    input  req, drv_data,
    output gnt, owner, bus_valid, bus
  );

  modport slave (
    output req, drv_data,
    input  gnt, owner, bus_valid, bus
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with a one-cycle turnaround between owners.
// Optional hold timeout is compiled in with macro BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.master  bif,
  output logic [1:0]     o_dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_owner;
  logic       r_valid;

  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_any_req;
  logic       w_expire;

  assign w_any_req = |bif.req;

  // Search starts just after the last owner, so that owner ends up lowest priority.
  always_comb begin
    w_winner = r_owner;
    w_found  = 1'b0;
    w_idx    = r_owner;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_owner + 2'(i);
      if (!w_found && bif.req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] r_hold;

  // r_hold counts grant cycles already completed; +1 includes the current one.
  assign w_expire = (({1'b0, r_hold} + 9'd1) >= {1'b0, TO8}) && |(bif.req & ~r_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= 8'd0;
    end else if (r_state != GRANT) begin
      r_hold <= 8'd0;
    end else if (r_hold < TO8) begin
      r_hold <= r_hold + 8'd1;
    end
  end
`else
  // A legal TIMEOUT is never zero, so this folds to constant low.
  assign w_expire = (TO8 == 8'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_owner <= 2'd3;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, TURN: begin
          if (w_any_req) begin
            r_state <= GRANT;
            r_gnt   <= 4'b0001 << w_winner;
            r_owner <= w_winner;
            r_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!bif.req[r_owner] || w_expire) begin
            r_state <= TURN;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bif.gnt       = r_gnt;
  assign bif.owner     = r_owner;
  assign bif.bus_valid = r_valid;
  assign bif.bus       = r_valid ? bif.drv_data[r_owner*DATA_W +: DATA_W] : '0;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter; expected per-cycle outputs are queued
// by the driver and popped by an independent monitor.
module tb_bus_arbiter;
  localparam int DW = 8;
  localparam int W  = 4 + 2 + 1 + DW;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [4*DW-1:0] drv;

  bus_arbiter_if #(.DATA_W(DW)) u_if ();

  bus_arbiter #(.DATA_W(DW), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bif         (u_if.master),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // driver: inputs change on the falling edge; the push is what the next rising edge must produce
  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] eo);
    logic [DW-1:0] eb;
    @(negedge clk);
    rst              = r;
    u_if.req         = rq;
    u_if.drv_data    = drv;
    eb               = (eg != 4'b0000) ? drv[eo*DW +: DW] : '0;
    exp_q.push_back({eg, eo, (eg != 4'b0000), eb});
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    #1;
    if (u_if.gnt & (u_if.gnt - 4'd1)) begin
      bad++;
      $display("FAIL onehot: gnt=%b required one-hot or zero", u_if.gnt);
    end
    if (!u_if.bus_valid && u_if.bus != '0) begin
      bad++;
      $display("FAIL bus_idle: bus=%h required 00 while bus_valid=0", u_if.bus);
    end
    total += 2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {u_if.gnt, u_if.owner, u_if.bus_valid, u_if.bus};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle@%0t: got gnt=%b owner=%0d valid=%b bus=%h, required gnt=%b owner=%0d valid=%b bus=%h",
                 $time, a[W-1 -: 4], a[W-5 -: 2], a[DW], a[DW-1:0],
                 e[W-1 -: 4], e[W-5 -: 2], e[DW], e[DW-1:0]);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    drv           = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    u_if.req      = 4'b0000;
    u_if.drv_data = drv;

    // reset state
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
    step(1'b1, 4'b0000, 4'b0000, 2'd3);

    // basic grant, release, turnaround, next winner, back to idle
    step(1'b0, 4'b0101, 4'b0001, 2'd0);
    step(1'b0, 4'b0101, 4'b0001, 2'd0);
    step(1'b0, 4'b0100, 4'b0000, 2'd0);
    step(1'b0, 4'b0100, 4'b0100, 2'd2);
    step(1'b0, 4'b0100, 4'b0100, 2'd2);
    step(1'b0, 4'b0000, 4'b0000, 2'd2);
    step(1'b0, 4'b0000, 4'b0000, 2'd2);
    step(1'b0, 4'b0000, 4'b0000, 2'd2);

    // full rotation with each owner holding two cycles, released owner re-asserting in TURN
    drv = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
    step(1'b0, 4'b1111, 4'b0001, 2'd0);
    step(1'b0, 4'b1111, 4'b0001, 2'd0);
    step(1'b0, 4'b1110, 4'b0000, 2'd0);
    step(1'b0, 4'b1111, 4'b0010, 2'd1);
    step(1'b0, 4'b1111, 4'b0010, 2'd1);
    step(1'b0, 4'b1101, 4'b0000, 2'd1);
    step(1'b0, 4'b1111, 4'b0100, 2'd2);
    step(1'b0, 4'b1111, 4'b0100, 2'd2);
    step(1'b0, 4'b1011, 4'b0000, 2'd2);
    step(1'b0, 4'b1111, 4'b1000, 2'd3);
    step(1'b0, 4'b1111, 4'b1000, 2'd3);
    step(1'b0, 4'b0111, 4'b0000, 2'd3);
    step(1'b0, 4'b1111, 4'b0001, 2'd0);

    // two requesters held constantly: timeout build alternates, default build holds owner 0
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0);
      step(1'b0, 4'b0011, 4'b0000, 2'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 4'b0010, 2'd1);
      step(1'b0, 4'b0011, 4'b0000, 2'd1);
    end
`else
    for (int i = 0; i < 12; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0);
`endif

    // release coinciding with the 4th grant cycle is an ordinary release
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0);
    step(1'b0, 4'b0010, 4'b0000, 2'd0);
    step(1'b0, 4'b0010, 4'b0010, 2'd1);

    // a sole requester keeps the bus for 20 cycles with no turnaround
    drv = {8'h9C, 8'h5A, 8'h3E, 8'h7F};
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1000, 4'b1000, 2'd3);

    // an unserved one-cycle pulse is not remembered
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
    step(1'b0, 4'b0001, 4'b0001, 2'd0);
    step(1'b0, 4'b0101, 4'b0001, 2'd0);
    step(1'b0, 4'b0001, 4'b0001, 2'd0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0);

    // reset in the middle of a grant, then release with everyone requesting
    step(1'b1, 4'b0000, 4'b0000, 2'd3);
    step(1'b0, 4'b0100, 4'b0100, 2'd2);
    step(1'b0, 4'b0100, 4'b0100, 2'd2);
    step(1'b1, 4'b0100, 4'b0000, 2'd3);
    step(1'b0, 4'b1111, 4'b0001, 2'd0);
    step(1'b0, 4'b1111, 4'b0001, 2'd0);

    // drain with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning shared-bus width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 8, meaning max consecutive GRANT cycles per owner when the timeout feature is compiled in; legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  4  bus request, one bit per requester (0=PC, 1=ACC, 2=RAM, 3=IR).
REQ-006 SHALL have port drv_data  input  4*DATA_W  requester data, packed; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port gnt  output  4  registered one-hot grant, or all-zero.
REQ-008 SHALL have port owner  output  2  registered index of current grantee; holds the last owner when gnt is zero.
REQ-009 SHALL have port bus_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-010 SHALL have port bus  output  DATA_W  combinational; drv_data slice of owner when bus_valid=1, else all-zero.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, GRANT, TURN (turnaround).
REQ-012 IDLE: gnt=0; if any req bit is high, SHALL move to GRANT and assert the winner's gnt bit on the next edge (one-cycle request-to-grant latency).
REQ-013 Winner SHALL be chosen round-robin: search order starts at (last_owner+1) mod 4, wrapping 3->0.
REQ-014 GRANT: gnt SHALL stay unchanged while req[owner]=1, regardless of other requests (unless REQ-022 applies).
REQ-015 GRANT: when req[owner]=0 is sampled, SHALL move to TURN; gnt drops to 0 on that edge.
REQ-016 TURN SHALL last exactly one cycle with gnt=0 (no back-to-back bus drivers); from TURN, if any req is high, SHALL move to GRANT with a new round-robin winner, else to IDLE.
REQ-017 A released owner that re-asserts req during TURN SHALL be arbitrated at lowest priority, per REQ-013.
REQ-018 Requests not granted SHALL NOT be latched; a req pulse dropped before arbitration is lost.
REQ-019 gnt SHALL never have more than one bit set in any cycle.
REQ-020 bus SHALL track drv_data[owner] within the same cycle; no registering of data.

Reset
REQ-021 While rst=1 at a rising edge: state=IDLE, gnt=4'b0000, bus_valid=0, owner=2'd3, last_owner=3, timeout counter=0; so requester 0 has top priority after reset. Reset asserted mid-GRANT SHALL drop gnt on that same edge.

Configuration
REQ-022 With macro BUS_ARB_TIMEOUT_EN defined: a hold counter SHALL count GRANT cycles; when it reaches TIMEOUT and any other req bit is high, SHALL move to TURN even if req[owner]=1; if no other request is pending, the grant SHALL continue and the counter saturates at TIMEOUT; the counter clears on entry to GRANT.
REQ-023 Without BUS_ARB_TIMEOUT_EN: no counter logic SHALL be present; an owner holds the bus indefinitely; TIMEOUT is ignored.
REQ-024 If timeout and owner release coincide in the same cycle, SHALL behave as a normal release (TURN, single transition).

Verification
REQ-025 Reset then req=4'b0101 held -> gnt=0001 one cycle later, owner=0, bus=drv_data[7:0]; drop req[0] -> TURN cycle gnt=0000, then gnt=0100, owner=2.
REQ-026 All four req held, each owner drops after 2 grant cycles, no timeout build -> grant order 0,1,2,3,0 with exactly one zero-gnt cycle between grants.
REQ-027 BUS_ARB_TIMEOUT_EN, TIMEOUT=4, req=4'b0011 held constantly -> gnt=0001 for 4 cycles, 1 TURN cycle, gnt=0010 for 4 cycles, repeat.
REQ-028 BUS_ARB_TIMEOUT_EN, TIMEOUT=4, req=4'b1000 only, held 20 cycles -> gnt=1000 continuous 20 cycles, no TURN.
REQ-029 rst=1 asserted while gnt=0100 -> next edge gnt=0000, bus_valid=0, owner=3, bus=8'h00; rst released with req=4'b1111 -> gnt=0001 one cycle later.
REQ-030 Every scenario: assertion that gnt is one-hot or zero and that bus=8'h00 whenever bus_valid=0.
